// File: rtl/deparser_lane_arbiter.sv
// Round-robin share of one deparser between two lanes: buffer each lane's PHV, strobe it, then pass the packet.
// Two cycles from eligibility to first beat. The granted lane's tready follows m_axis_tready, and the other lane is held off.
module deparser_lane_arbiter #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int PKT_HDR_LEN          = 1124
) (
  input  logic                              axis_clk,
  input  logic                              aresetn,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
  input  logic                              s0_axis_tvalid,
  input  logic                              s0_axis_tlast,
  output logic                              s0_axis_tready,
  input  logic                              s0_phv_valid,
  input  logic [PKT_HDR_LEN-1:0]            s0_phv,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
  input  logic                              s1_axis_tvalid,
  input  logic                              s1_axis_tlast,
  output logic                              s1_axis_tready,
  input  logic                              s1_phv_valid,
  input  logic [PKT_HDR_LEN-1:0]            s1_phv,

  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,

  output logic                              phv_valid_out,
  output logic [PKT_HDR_LEN-1:0]            phv_out,
  output logic                              grant,
  output logic [1:0]                        phv_drop
);

  typedef enum logic [1:0] {IDLE, PHV, PKT} state_t;

  state_t                   state_q, state_d;
  logic                     grant_q, grant_d;
  logic                     rr_q, rr_d;
  logic [1:0]               full_q, full_d;
  logic [1:0]               drop_q, drop_d;
  logic [1:0]               wr_en;
  logic [1:0]               consume;
  logic [1:0]               elig;
  logic [PKT_HDR_LEN-1:0]   buf0_q, buf1_q;
  logic                     phv_vld_q, phv_vld_d;
  logic [PKT_HDR_LEN-1:0]   phv_out_q, phv_out_d;
  logic                     in_pkt;

  assign in_pkt = (state_q == PKT);
  assign elig   = full_q & {s1_axis_tvalid, s0_axis_tvalid};

  // A lane's buffer is read out during the PHV cycle, so a write then is a refill, not an overflow.
  always_comb begin
    consume    = 2'b00;
    consume[0] = (state_q == PHV) && !grant_q;
    consume[1] = (state_q == PHV) &&  grant_q;
    wr_en[0]   = s0_phv_valid && (!full_q[0] || consume[0]);
    wr_en[1]   = s1_phv_valid && (!full_q[1] || consume[1]);
    drop_d[0]  = s0_phv_valid && full_q[0] && !consume[0];
    drop_d[1]  = s1_phv_valid && full_q[1] && !consume[1];
    full_d[0]  = s0_phv_valid || (full_q[0] && !consume[0]);
    full_d[1]  = s1_phv_valid || (full_q[1] && !consume[1]);
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    phv_vld_d = 1'b0;
    phv_out_d = phv_out_q;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          grant_d   = elig[rr_q] ? rr_q : ~rr_q;
          state_d   = PHV;
          phv_vld_d = 1'b1;
          phv_out_d = grant_d ? buf1_q : buf0_q;
        end
      end
      PHV: state_d = PKT;
      PKT: begin
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          rr_d    = ~grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      rr_q      <= 1'b0;
      full_q    <= 2'b00;
      drop_q    <= 2'b00;
      buf0_q    <= '0;
      buf1_q    <= '0;
      phv_vld_q <= 1'b0;
      phv_out_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      full_q    <= full_d;
      drop_q    <= drop_d;
      phv_vld_q <= phv_vld_d;
      phv_out_q <= phv_out_d;
      if (wr_en[0]) buf0_q <= s0_phv;
      if (wr_en[1]) buf1_q <= s1_phv;
    end
  end

  always_comb begin
    m_axis_tdata   = grant_q ? s1_axis_tdata : s0_axis_tdata;
    m_axis_tuser   = grant_q ? s1_axis_tuser : s0_axis_tuser;
    m_axis_tkeep   = grant_q ? s1_axis_tkeep : s0_axis_tkeep;
    m_axis_tlast   = grant_q ? s1_axis_tlast : s0_axis_tlast;
    m_axis_tvalid  = in_pkt && (grant_q ? s1_axis_tvalid : s0_axis_tvalid);
    s0_axis_tready = in_pkt && !grant_q && m_axis_tready;
    s1_axis_tready = in_pkt &&  grant_q && m_axis_tready;
  end

  assign phv_valid_out = phv_vld_q;
  assign phv_out       = phv_out_q;
  assign grant         = grant_q;
  assign phv_drop      = drop_q;

endmodule

// File: tb/tb_deparser_lane_arbiter.sv
// Directed bench for deparser_lane_arbiter: single lane, round-robin, backpressure, PHV overflow/refill, reset.
module tb_deparser_lane_arbiter;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int HL = 1124;

  logic            axis_clk;
  logic            aresetn;
  logic [DW-1:0]   s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic [UW-1:0]   s0_axis_tuser, s1_axis_tuser, m_axis_tuser;
  logic [DW/8-1:0] s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
  logic            s0_axis_tvalid, s1_axis_tvalid, m_axis_tvalid;
  logic            s0_axis_tlast, s1_axis_tlast, m_axis_tlast;
  logic            s0_axis_tready, s1_axis_tready, m_axis_tready;
  logic            s0_phv_valid, s1_phv_valid, phv_valid_out;
  logic [HL-1:0]   s0_phv, s1_phv, phv_out;
  logic            grant;
  logic [1:0]      phv_drop;

  int checks = 0;
  int errors = 0;
  int cnt [2];

  deparser_lane_arbiter #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .PKT_HDR_LEN         (HL)
  ) dut (
    .axis_clk      (axis_clk),
    .aresetn       (aresetn),
    .s0_axis_tdata (s0_axis_tdata),
    .s0_axis_tuser (s0_axis_tuser),
    .s0_axis_tkeep (s0_axis_tkeep),
    .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tlast (s0_axis_tlast),
    .s0_axis_tready(s0_axis_tready),
    .s0_phv_valid  (s0_phv_valid),
    .s0_phv        (s0_phv),
    .s1_axis_tdata (s1_axis_tdata),
    .s1_axis_tuser (s1_axis_tuser),
    .s1_axis_tkeep (s1_axis_tkeep),
    .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tlast (s1_axis_tlast),
    .s1_axis_tready(s1_axis_tready),
    .s1_phv_valid  (s1_phv_valid),
    .s1_phv        (s1_phv),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .phv_valid_out (phv_valid_out),
    .phv_out       (phv_out),
    .grant         (grant),
    .phv_drop      (phv_drop)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  function automatic logic [HL-1:0] mk_phv(input logic [7:0] b);
    return {4'h0, {140{b}}};
  endfunction

  function automatic logic [DW-1:0] mk_dat(input logic [7:0] lane, input logic [7:0] n);
    return {240'h0, lane, n};
  endfunction

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    aresetn        = 1'b0;
    m_axis_tready  = 1'b1;
    s0_axis_tdata  = '0; s1_axis_tdata = '0;
    s0_axis_tuser  = 128'h0000_00AA; s1_axis_tuser = 128'h0000_00BB;
    s0_axis_tkeep  = '1; s1_axis_tkeep = '1;
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
    s0_axis_tlast  = 1'b0; s1_axis_tlast  = 1'b0;
    s0_phv_valid   = 1'b0; s1_phv_valid   = 1'b0;
    s0_phv         = '0; s1_phv = '0;

    // Reset values
    tick(); tick();
    chk("rst_phv_valid_out", 256'(phv_valid_out), 256'(0));
    chk("rst_phv_out_zero", 256'(phv_out === '0), 256'(1));
    chk("rst_grant", 256'(grant), 256'(0));
    chk("rst_phv_drop", 256'(phv_drop), 256'(0));
    chk("rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
    chk("rst_s0_tready", 256'(s0_axis_tready), 256'(0));
    aresetn = 1'b1;
    tick();

    // Test 1: lane 0 alone, 3-beat packet
    s0_phv_valid = 1'b1; s0_phv = mk_phv(8'hA5);
    s0_axis_tvalid = 1'b1; s0_axis_tdata = mk_dat(8'h00, 8'h01); s0_axis_tlast = 1'b0;
    tick();
    s0_phv_valid = 1'b0;
    #1 chk("t1_idle_no_tvalid", 256'(m_axis_tvalid), 256'(0));
    tick();
    chk("t1_phv_strobe", 256'(phv_valid_out), 256'(1));
    chk("t1_phv_a5", 256'(phv_out === mk_phv(8'hA5)), 256'(1));
    chk("t1_phv_state_no_tvalid", 256'(m_axis_tvalid), 256'(0));
    tick();
    chk("t1_strobe_one_cycle", 256'(phv_valid_out), 256'(0));
    chk("t1_b1_tvalid", 256'(m_axis_tvalid), 256'(1));
    chk("t1_b1_tdata", m_axis_tdata, mk_dat(8'h00, 8'h01));
    chk("t1_b1_tuser", 256'(m_axis_tuser), 256'(128'hAA));
    chk("t1_s0_tready", 256'(s0_axis_tready), 256'(1));
    tick();
    s0_axis_tdata = mk_dat(8'h00, 8'h02);
    #1 chk("t1_b2_tdata", m_axis_tdata, mk_dat(8'h00, 8'h02));
    chk("t1_b2_tlast", 256'(m_axis_tlast), 256'(0));
    tick();
    s0_axis_tdata = mk_dat(8'h00, 8'h03); s0_axis_tlast = 1'b1;
    #1 chk("t1_b3_tdata", m_axis_tdata, mk_dat(8'h00, 8'h03));
    chk("t1_b3_tlast", 256'(m_axis_tlast), 256'(1));
    tick();
    s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0;
    #1 chk("t1_after_tlast_idle", 256'(m_axis_tvalid), 256'(0));

    // Test 2: both lanes eligible, 4 single-beat packets each; rr points at lane 1 now
    cnt[0] = 0; cnt[1] = 0;
    s0_axis_tdata = mk_dat(8'h00, 8'h00); s1_axis_tdata = mk_dat(8'h01, 8'h00);
    s0_axis_tlast = 1'b1; s1_axis_tlast = 1'b1;
    s0_axis_tvalid = 1'b1; s1_axis_tvalid = 1'b1;
    s0_phv_valid = 1'b1; s0_phv = mk_phv(8'h20);
    s1_phv_valid = 1'b1; s1_phv = mk_phv(8'h30);
    tick();
    s0_phv_valid = 1'b0; s1_phv_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bit el;
      el = (k % 2 == 0);
      tick();
      chk("t2_grant", 256'(grant), 256'(el));
      chk("t2_phv_strobe", 256'(phv_valid_out), 256'(1));
      chk("t2_phv_value", 256'(phv_out === (el ? mk_phv(8'(32'h30 + cnt[1])) : mk_phv(8'(32'h20 + cnt[0])))), 256'(1));
      tick();
      chk("t2_tdata", m_axis_tdata, mk_dat(8'(el), 8'(cnt[el])));
      chk("t2_loser_tready", 256'(el ? s0_axis_tready : s1_axis_tready), 256'(0));
      if (k < 6) begin
        if (el) begin s1_phv_valid = 1'b1; s1_phv = mk_phv(8'(32'h31 + cnt[1])); end
        else    begin s0_phv_valid = 1'b1; s0_phv = mk_phv(8'(32'h21 + cnt[0])); end
      end
      tick();
      s0_phv_valid = 1'b0; s1_phv_valid = 1'b0;
      cnt[el] = cnt[el] + 1;
      if (el) s1_axis_tdata = mk_dat(8'h01, 8'(cnt[1]));
      else    s0_axis_tdata = mk_dat(8'h00, 8'(cnt[0]));
    end
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
    s0_axis_tlast = 1'b0; s1_axis_tlast = 1'b0;

    // Test 3: lane 1 packet under m_axis_tready toggling
    s1_phv_valid = 1'b1; s1_phv = mk_phv(8'h5A);
    s1_axis_tvalid = 1'b1; s1_axis_tdata = mk_dat(8'h01, 8'hB1);
    tick();
    s1_phv_valid = 1'b0;
    tick();
    chk("t3_grant", 256'(grant), 256'(1));
    tick();
    m_axis_tready = 1'b0;
    #1 chk("t3_tready_follow0", 256'(s1_axis_tready), 256'(0));
    chk("t3_b1_tdata", m_axis_tdata, mk_dat(8'h01, 8'hB1));
    tick();
    chk("t3_b1_held", m_axis_tdata, mk_dat(8'h01, 8'hB1));
    chk("t3_b1_tvalid_held", 256'(m_axis_tvalid), 256'(1));
    m_axis_tready = 1'b1;
    #1 chk("t3_tready_follow1", 256'(s1_axis_tready), 256'(1));
    chk("t3_s0_tready_off", 256'(s0_axis_tready), 256'(0));
    tick();
    s1_axis_tdata = mk_dat(8'h01, 8'hB2); s1_axis_tlast = 1'b1; m_axis_tready = 1'b0;
    #1 chk("t3_b2_tdata", m_axis_tdata, mk_dat(8'h01, 8'hB2));
    tick();
    chk("t3_b2_held", m_axis_tdata, mk_dat(8'h01, 8'hB2));
    m_axis_tready = 1'b1;
    tick();
    s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0;
    #1 chk("t3_done_idle", 256'(m_axis_tvalid), 256'(0));

    // Test 4/5: overflow drop, then refill during the PHV cycle
    s0_phv_valid = 1'b1; s0_phv = mk_phv(8'h11);
    tick();
    s0_phv = mk_phv(8'h22);
    tick();
    chk("t4_drop_pulse", 256'(phv_drop), 256'(2'b01));
    s0_phv_valid = 1'b0;
    tick();
    chk("t4_drop_once", 256'(phv_drop), 256'(0));
    s0_axis_tvalid = 1'b1; s0_axis_tlast = 1'b1; s0_axis_tdata = mk_dat(8'h00, 8'hC1);
    tick();
    chk("t4_first_phv_kept", 256'(phv_out === mk_phv(8'h11)), 256'(1));
    chk("t4_grant", 256'(grant), 256'(0));
    s0_phv_valid = 1'b1; s0_phv = mk_phv(8'h33);
    tick();
    chk("t5_no_drop", 256'(phv_drop), 256'(0));
    chk("t5_pkt_tvalid", 256'(m_axis_tvalid), 256'(1));
    s0_phv_valid = 1'b0;
    tick();
    tick();
    chk("t5_second_strobe", 256'(phv_valid_out), 256'(1));
    chk("t5_refilled_phv", 256'(phv_out === mk_phv(8'h33)), 256'(1));
    tick();
    chk("t5_second_pkt", m_axis_tdata, mk_dat(8'h00, 8'hC1));
    tick();
    s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0;

    // Test 6: reset on beat 2 of a lane 0 packet
    s0_phv_valid = 1'b1; s0_phv = mk_phv(8'h44);
    s0_axis_tvalid = 1'b1; s0_axis_tdata = mk_dat(8'h00, 8'hD1);
    tick();
    s0_phv_valid = 1'b0;
    tick(); tick();
    chk("t6_b1_tvalid", 256'(m_axis_tvalid), 256'(1));
    tick();
    s0_axis_tdata = mk_dat(8'h00, 8'hD2);
    #1 chk("t6_b2_tdata", m_axis_tdata, mk_dat(8'h00, 8'hD2));
    aresetn = 1'b0;
    #1 chk("t6_rst_tvalid", 256'(m_axis_tvalid), 256'(0));
    chk("t6_rst_tready", 256'(s0_axis_tready), 256'(0));
    chk("t6_rst_phv_out", 256'(phv_out === '0), 256'(1));
    chk("t6_rst_grant", 256'(grant), 256'(0));
    tick(); tick();
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_beat_after_rst", 256'(m_axis_tvalid), 256'(0));
      chk("t6_no_strobe_after_rst", 256'(phv_valid_out), 256'(0));
    end
    s0_phv_valid = 1'b1; s0_phv = mk_phv(8'h55);
    tick();
    s0_phv_valid = 1'b0;
    tick();
    chk("t6_new_phv", 256'(phv_out === mk_phv(8'h55)), 256'(1));
    tick();
    chk("t6_new_pkt_tvalid", 256'(m_axis_tvalid), 256'(1));
    s0_axis_tlast = 1'b1;
    tick();
    s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0;
    #1 chk("t6_end_idle", 256'(m_axis_tvalid), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
